prng_range_seq: RTL
===================

// Module: prng_range_seq
// PURPOSE
//  Sequencer upstream of the iterative divider (div). Holds the PRNG state; on request advances it, drives the divider
//  with (random, bound) and returns the remainder as a uniform-ish value in [0, bound). Owns the divider's en/y/x inputs.
//  Consumes the divider's r/done outputs. Presents a single req -> out_valid result interface to the PRNG top level.
// PARAMETERS
//  LCG_A         32'd1664525     LCG multiplier
//  LCG_C         32'd1013904223  LCG increment
//  SEED_DEFAULT  32'd1           PRNG state after reset
//  TIMEOUT       16'd200         max cycles waited for div_done before aborting
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst        in   1   asynchronous, active-high reset
//  seed_load  in   1   load seed into PRNG state (honoured in IDLE only)
//  seed       in   32  seed value
//  req        in   1   request one ranged random value (sampled in IDLE only)
//  bound      in   32  exclusive upper bound, captured with req
//  busy       out  1   high whenever FSM is not IDLE
//  out_valid  out  1   one-cycle pulse: out_data/err valid
//  out_data   out  32  result, held until next out_valid
//  err        out  1   with out_valid: bound==0 or divider timeout
//  div_en     out  1   to div.en, registered, high exactly one cycle per operation
//  div_y      out  32  to div.y (dividend)
//  div_x      out  32  to div.x (divisor)
//  div_r      in   32  from div.r
//  div_done   in   1   from div.done
// BEHAVIOUR
//  Reset: state=SEED_DEFAULT, FSM=IDLE, busy=0, out_valid=0, out_data=0, err=0, div_en=0, div_y=0, div_x=0, timer=0.
//  FSM: IDLE -> STEP -> ISSUE -> SETTLE -> WAIT -> IDLE.
//  IDLE: seed_load -> state<=seed. req -> capture bound, go STEP. Both same cycle: load seed, then STEP from new seed.
//   req with bound==0: no divider op; next cycle out_valid=1, err=1, out_data=0; stay IDLE.
//  STEP: state <= state*LCG_A + LCG_C (mod 2^32).
//  ISSUE: div_en=1, div_y={1'b0,state[31:1]}, div_x=bound. div_y/div_x held until next ISSUE.
//   Dividend MSB is forced 0 so the divider's signed compares stay valid.
//  SETTLE: div_en=0; one cycle, div_done ignored (guards against a stale done pulse).
//  WAIT: timer increments each cycle. div_done=1 -> out_data<=div_r, err<=0, out_valid pulse, timer<=0, go IDLE.
//   timer reaches TIMEOUT-1 without div_done -> out_valid=1, err=1, out_data=0, go IDLE.
//   div_done and timeout in the same cycle: div_done wins.
//  Latency req->out_valid: 4 + (divider cycles from en low to done). bound==1 goes through the divider, result 0.
//  req/seed_load while busy: ignored, not queued. State advances once per accepted req, including timeouts.
//  Reset mid-operation: immediate return to reset values; div_en drops asynchronously.
//   The divider is re-armed by the next ISSUE.
// CONFIGURATION
//  PRNG_XORSHIFT_EN defined: STEP uses xorshift32 instead of the LCG:
//   x^=x<<13; x^=x>>17; x^=x<<5, combinational within one cycle.
//   LCG_A/LCG_C are unused. A seed of 0 loads SEED_DEFAULT instead, because xorshift locks up at 0.
//  Not defined: LCG as above; a seed of 0 is legal.
// TESTING  (bench instantiates real div)
//  1 reset, seed_load seed=1, req bound=10 -> div_y=507784374, div_x=10; out_valid once, out_data=4, err=0.
//  2 req bound=0 -> out_valid next cycle, err=1, out_data=0, div_en never asserted, PRNG state unchanged.
//  3 div_done stubbed low, TIMEOUT=200 -> out_valid exactly 200 cycles after entering WAIT, err=1; busy falls same edge.
//  4 req pulsed during WAIT and a seed_load during STEP -> both ignored; single out_valid; next req continues sequence.
//  5 rst asserted in WAIT -> div_en=0, busy=0, out_data=0 immediately; next req from seed=1 repeats scenario 1 result.
//  6 PRNG_XORSHIFT_EN, seed=1, req bound=1000 -> state=270369, div_y=135184, out_data=184.
//    seed_load seed=0 -> state=SEED_DEFAULT.

Source files
------------

// File: rtl/prng_range_seq.sv
// -----------------------------------------------------------------------------
// prng_range_seq
//
// Purpose
//   Sequencer that sits in front of the iterative divider. It owns the PRNG
//   state. Each accepted request advances that state once, hands
//   (random >> 1, bound) to the divider, and returns the remainder as a value
//   in [0, bound). A bound of 0 and a divider that never answers both end in
//   an error result.
//
// Configuration macro
//   PRNG_XORSHIFT_EN : the step function is xorshift32 (13/17/5) instead of
//                      the LCG. A seed of 0 loads SEED_DEFAULT, because
//                      xorshift32 never leaves the all-zero state.
//
// Ports
//   clk          in   1   clock, all logic on posedge
//   rst          in   1   asynchronous active-high reset
//   seed_load    in   1   load seed into PRNG state (IDLE only)
//   seed         in   32  seed value
//   req          in   1   request one ranged value (IDLE only)
//   bound        in   32  exclusive upper bound, captured with req
//   busy         out  1   FSM not in IDLE
//   out_valid    out  1   one-cycle pulse, out_data/err valid
//   out_data     out  32  result, held until the next out_valid
//   err          out  1   with out_valid: bound==0 or divider timeout
//   div_en       out  1   divider start, high for exactly one cycle per op
//   div_y        out  32  divider dividend
//   div_x        out  32  divider divisor
//   div_r        in   32  divider remainder
//   div_done     in   1   divider completion strobe
//   o_dbg_state  out  3   current FSM state (debug)
//
// Handshake
//   req is sampled only while busy is low. Requests and seed loads that
//   arrive while busy is high are dropped, not queued. Each accepted request
//   produces exactly one out_valid pulse. The pulse has no backpressure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module prng_range_seq #(
    parameter logic [31:0] LCG_A        = 32'd1664525,
    parameter logic [31:0] LCG_C        = 32'd1013904223,
    parameter logic [31:0] SEED_DEFAULT = 32'd1,
    parameter logic [15:0] TIMEOUT      = 16'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [31:0] seed,
    input  logic        req,
    input  logic [31:0] bound,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        err,
    output logic        div_en,
    output logic [31:0] div_y,
    output logic [31:0] div_x,
    input  logic [31:0] div_r,
    input  logic        div_done,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STEP   = 3'd1,
        S_ISSUE  = 3'd2,
        S_SETTLE = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_prng;
    logic [31:0] r_bound;
    logic [15:0] r_timer;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_err;
    logic        r_div_en;
    logic [31:0] r_div_y;
    logic [31:0] r_div_x;

    state_t      w_state_nxt;
    logic [31:0] w_prng_nxt;
    logic [31:0] w_bound_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_out_valid_nxt;
    logic [31:0] w_out_data_nxt;
    logic        w_err_nxt;
    logic        w_div_en_nxt;
    logic [31:0] w_div_y_nxt;
    logic [31:0] w_div_x_nxt;

    logic [31:0] w_seed_val;
    logic [31:0] w_step;

`ifdef PRNG_XORSHIFT_EN
    logic [31:0] w_xs1;
    logic [31:0] w_xs2;
    logic        w_unused_lcg;

    assign w_xs1      = r_prng ^ (r_prng << 13);
    assign w_xs2      = w_xs1 ^ (w_xs1 >> 17);
    assign w_step     = w_xs2 ^ (w_xs2 << 5);
    // A zero seed would lock xorshift at zero forever.
    assign w_seed_val = (seed == 32'd0) ? SEED_DEFAULT : seed;
    assign w_unused_lcg = ^{LCG_A, LCG_C};
`else
    assign w_step     = r_prng * LCG_A + LCG_C;
    assign w_seed_val = seed;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_prng_nxt      = r_prng;
        w_bound_nxt     = r_bound;
        w_timer_nxt     = r_timer;
        w_out_valid_nxt = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_err_nxt       = r_err;
        w_div_en_nxt    = 1'b0;
        w_div_y_nxt     = r_div_y;
        w_div_x_nxt     = r_div_x;

        case (r_state)
            S_IDLE: begin
                // The seed loads first. A req in the same cycle then steps
                // from the new seed, because STEP reads r_prng next cycle.
                if (seed_load) begin
                    w_prng_nxt = w_seed_val;
                end
                if (req) begin
                    if (bound == 32'd0) begin
                        w_out_valid_nxt = 1'b1;
                        w_err_nxt       = 1'b1;
                        w_out_data_nxt  = 32'd0;
                    end else begin
                        w_bound_nxt = bound;
                        w_state_nxt = S_STEP;
                    end
                end
            end
            S_STEP: begin
                // Register the stepped state and the divider operands
                // together, so div_en is high for the whole ISSUE cycle.
                // The dividend MSB is cleared because the divider compares
                // its operands as signed values.
                w_prng_nxt   = w_step;
                w_div_en_nxt = 1'b1;
                w_div_y_nxt  = {1'b0, w_step[31:1]};
                w_div_x_nxt  = r_bound;
                w_state_nxt  = S_ISSUE;
            end
            S_ISSUE: begin
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                // div_done is ignored for this one cycle. A done pulse left
                // over from an earlier operation must not be taken as the
                // answer to this one.
                w_timer_nxt = 16'd0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = div_r;
                    w_err_nxt       = 1'b0;
                    w_timer_nxt     = 16'd0;
                    w_state_nxt     = S_IDLE;
                end else if (r_timer == TIMEOUT - 16'd1) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = 32'd0;
                    w_err_nxt       = 1'b1;
                    w_timer_nxt     = 16'd0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_prng      <= SEED_DEFAULT;
            r_bound     <= 32'd0;
            r_timer     <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_err       <= 1'b0;
            r_div_en    <= 1'b0;
            r_div_y     <= 32'd0;
            r_div_x     <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_prng      <= w_prng_nxt;
            r_bound     <= w_bound_nxt;
            r_timer     <= w_timer_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_err       <= w_err_nxt;
            r_div_en    <= w_div_en_nxt;
            r_div_y     <= w_div_y_nxt;
            r_div_x     <= w_div_x_nxt;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign err         = r_err;
    assign div_en      = r_div_en;
    assign div_y       = r_div_y;
    assign div_x       = r_div_x;
    assign o_dbg_state = r_state;

endmodule
